// File: rtl/switch_debounce_pair.sv
// Two-channel switch conditioner: per-channel synchroniser and debounce FSM.
// Drives clean a/b levels, one-cycle change strobes and a settled flag.
module switch_debounce_pair #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a_raw,
  input  logic sw_b_raw,
  output logic a,
  output logic b,
  output logic a_chg,
  output logic b_chg,
  output logic settled
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] chg;
  logic [1:0] idle_nxt;

  assign raw = {sw_b_raw, sw_a_raw};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   syn;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   x;
    logic                   x_chg;
    logic                   diff;
    logic                   done;

    assign syn  = sync[SYNC_STAGES-1];
    assign diff = (syn != x);
    assign done = (cnt == LAST);

    // a channel is idle next cycle unless it keeps counting
    assign idle_nxt[i] = !diff || done;
    assign lvl[i]      = x;
    assign chg[i]      = x_chg;

    // plain shift chain bringing the raw switch into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[i]};
      end
    end

    // qualify a new level for STABLE_COUNT consecutive cycles
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        x     <= 1'b0;
        x_chg <= 1'b0;
      end else begin
        x_chg <= 1'b0;
        unique case (state)
          IDLE: begin
            if (diff) begin
              if (done) begin
                x     <= syn;
                x_chg <= 1'b1;
                cnt   <= '0;
              end else begin
                cnt   <= cnt + 1'b1;
                state <= COUNT;
              end
            end
          end
          COUNT: begin
            if (!diff) begin
              cnt   <= '0;
              state <= IDLE;
            end else if (done) begin
              x     <= syn;
              x_chg <= 1'b1;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // settled tracks the next state so it drops on the first counting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settled <= 1'b1;
    end else begin
      settled <= &idle_nxt;
    end
  end

  assign a     = lvl[0];
  assign b     = lvl[1];
  assign a_chg = chg[0];
  assign b_chg = chg[1];

endmodule
